// File: rtl/bc_arbiter_if.sv
// Breadcrumb arbiter bus: two producer handshakes (Avoidance, PWM) and
// the write side of the shared breadcrumb FIFO.
interface bc_arbiter_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] avoid_data;
    logic              avoid_valid;
    logic              avoid_rdy;
    logic [DATA_W-1:0] pwm_data;
    logic              pwm_valid;
    logic              pwm_rdy;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_rdy;

    // Arbiter side
    modport slave (
        input  avoid_data, avoid_valid,
        output avoid_rdy,
        input  pwm_data, pwm_valid,
        output pwm_rdy,
        output out_data, out_valid,
        input  out_rdy
    );

    // Producer / FIFO side
    modport master (
        output avoid_data, avoid_valid,
        input  avoid_rdy,
        output pwm_data, pwm_valid,
        input  pwm_rdy,
        input  out_data, out_valid,
        output out_rdy
    );
endinterface

// File: rtl/bc_arbiter.sv
// Two-source burst arbiter feeding one breadcrumb FIFO write port.
// The owner's handshake is passed straight through (no added latency);
// ownership changes after MAX_BURST words when the other source waits,
// or as soon as the owner runs dry. Per-source word counters saturate.
module bc_arbiter #(
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 8     // legal range 1..255
) (
    input  logic        clk,
    input  logic        rst,        // synchronous, active low
    bc_arbiter_if.slave bus,
    output logic [1:0]  grant,
    output logic        busy,
    input  logic        clr_cnt,
    output logic [15:0] avoid_cnt,
    output logic [15:0] pwm_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_A = 2'b01,
        GNT_P = 2'b10
    } state_t;

    // last_owner encoding: 0 = Avoidance, 1 = PWM
    localparam logic       OWN_A      = 1'b0;
    localparam logic       OWN_P      = 1'b1;
    // burst_cnt value seen on the transfer that completes a full burst
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    state_t      state_q, state_d;
    logic        last_owner_q, last_owner_d;
    logic [7:0]  burst_cnt_q, burst_cnt_d;
    logic [15:0] avoid_cnt_q, avoid_cnt_d;
    logic [15:0] pwm_cnt_q, pwm_cnt_d;

    logic        xfer_a, xfer_p;

    // Owner pass-through: data/valid/ready follow the grant combinationally
    always_comb begin
        bus.out_data  = '0;
        bus.out_valid = 1'b0;
        bus.avoid_rdy = 1'b0;
        bus.pwm_rdy   = 1'b0;
        case (state_q)
            GNT_A: begin
                bus.out_data  = bus.avoid_data;
                bus.out_valid = bus.avoid_valid;
                bus.avoid_rdy = bus.out_rdy;
            end
            GNT_P: begin
                bus.out_data  = bus.pwm_data;
                bus.out_valid = bus.pwm_valid;
                bus.pwm_rdy   = bus.out_rdy;
            end
            default: ;
        endcase
    end

    // A word moves only when the granted source is valid and the FIFO has room
    assign xfer_a = (state_q == GNT_A) && bus.avoid_valid && bus.out_rdy;
    assign xfer_p = (state_q == GNT_P) && bus.pwm_valid && bus.out_rdy;

    // grant comes from the state register only, so it is glitch-free
    assign grant = {state_q == GNT_P, state_q == GNT_A};
    assign busy  = (state_q != IDLE);

    // Ownership and burst-length control
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        case (state_q)
            IDLE: begin
                burst_cnt_d = '0;
                if (bus.avoid_valid && bus.pwm_valid) begin
                    // Tie: whoever did not own last goes first
                    state_d = (last_owner_q == OWN_P) ? GNT_A : GNT_P;
                end else if (bus.avoid_valid) begin
                    state_d = GNT_A;
                end else if (bus.pwm_valid) begin
                    state_d = GNT_P;
                end
            end
            GNT_A: begin
                if (!bus.avoid_valid) begin
                    state_d      = bus.pwm_valid ? GNT_P : IDLE;
                    last_owner_d = OWN_A;
                    burst_cnt_d  = '0;
                end else if (xfer_a) begin
                    if (burst_cnt_q == BURST_LAST) begin
                        // Full burst: hand over if PWM waits, else restart burst
                        burst_cnt_d = '0;
                        if (bus.pwm_valid) begin
                            state_d      = GNT_P;
                            last_owner_d = OWN_A;
                        end
                    end else begin
                        burst_cnt_d = burst_cnt_q + 8'd1;
                    end
                end
            end
            GNT_P: begin
                if (!bus.pwm_valid) begin
                    state_d      = bus.avoid_valid ? GNT_A : IDLE;
                    last_owner_d = OWN_P;
                    burst_cnt_d  = '0;
                end else if (xfer_p) begin
                    if (burst_cnt_q == BURST_LAST) begin
                        burst_cnt_d = '0;
                        if (bus.avoid_valid) begin
                            state_d      = GNT_A;
                            last_owner_d = OWN_P;
                        end
                    end else begin
                        burst_cnt_d = burst_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    // Saturating word counters; clear beats a same-cycle transfer
    always_comb begin
        avoid_cnt_d = avoid_cnt_q;
        pwm_cnt_d   = pwm_cnt_q;
        if (clr_cnt) begin
            avoid_cnt_d = '0;
            pwm_cnt_d   = '0;
        end else begin
            if (xfer_a && (avoid_cnt_q != CNT_MAX)) avoid_cnt_d = avoid_cnt_q + 16'd1;
            if (xfer_p && (pwm_cnt_q != CNT_MAX))   pwm_cnt_d   = pwm_cnt_q + 16'd1;
        end
    end

    // State registers; reset aborts any grant and drops the in-flight word count
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_owner_q <= OWN_P;
            burst_cnt_q  <= '0;
            avoid_cnt_q  <= '0;
            pwm_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            avoid_cnt_q  <= avoid_cnt_d;
            pwm_cnt_q    <= pwm_cnt_d;
        end
    end

    assign avoid_cnt = avoid_cnt_q;
    assign pwm_cnt   = pwm_cnt_q;

endmodule

// File: tb/tb_bc_arbiter.sv
// Directed bench for bc_arbiter: reset, alternating bursts, single-source
// streaming, stall hold, counter saturation/clear and mid-burst reset.
module tb_bc_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_cnt;
    logic [1:0]  grant;
    logic        busy;
    logic [15:0] avoid_cnt;
    logic [15:0] pwm_cnt;
    logic        chk_en = 1'b0;

    int ncmp = 0;
    int nerr = 0;

    bc_arbiter_if #(.DATA_W(16)) bus ();

    bc_arbiter #(.DATA_W(16), .MAX_BURST(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .grant     (grant),
        .busy      (busy),
        .clr_cnt   (clr_cnt),
        .avoid_cnt (avoid_cnt),
        .pwm_cnt   (pwm_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then settle before the caller drives/checks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle-by-cycle invariants, sampled mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            chk("inv_both_rdy", {31'd0, bus.avoid_rdy & bus.pwm_rdy}, 32'd0);
            chk("inv_valid_no_grant", {31'd0, bus.out_valid & (grant == 2'b00)}, 32'd0);
            if (bus.out_valid) begin
                if (grant == 2'b01) chk("inv_data_a", {16'd0, bus.out_data}, {16'd0, bus.avoid_data});
                else                chk("inv_data_p", {16'd0, bus.out_data}, {16'd0, bus.pwm_data});
            end
        end
    end

    initial begin
        rst             = 1'b0;
        clr_cnt         = 1'b0;
        bus.avoid_data  = 16'h0000;
        bus.avoid_valid = 1'b0;
        bus.pwm_data    = 16'h0000;
        bus.pwm_valid   = 1'b0;
        bus.out_rdy     = 1'b0;

        // ---- Reset state
        tick();
        tick();
        chk_en = 1'b1;
        #1;
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, bus.out_data}, 32'd0);
        chk("rst_avoid_cnt", {16'd0, avoid_cnt}, 32'd0);
        chk("rst_pwm_cnt", {16'd0, pwm_cnt}, 32'd0);

        // ---- Both sources valid: 8-word bursts alternate, Avoidance first
        tick();
        rst             = 1'b1;
        bus.avoid_valid = 1'b1;
        bus.pwm_valid   = 1'b1;
        bus.out_rdy     = 1'b1;
        #1;
        chk("alt_idle_first", {30'd0, grant}, 32'd0);
        chk("alt_idle_rdy", {30'd0, bus.avoid_rdy, bus.pwm_rdy}, 32'd0);
        for (int k = 0; k < 32; k++) begin
            tick();
            bus.avoid_data = 16'hA000 | 16'(k);
            bus.pwm_data   = 16'hB000 | 16'(k);
            #1;
            chk($sformatf("alt_grant_%0d", k), {30'd0, grant},
                ((k / 8) % 2 == 0) ? 32'd1 : 32'd2);
        end
        tick();
        bus.avoid_valid = 1'b0;
        bus.pwm_valid   = 1'b0;
        #1;
        chk("alt_avoid_cnt", {16'd0, avoid_cnt}, 32'd16);
        chk("alt_pwm_cnt", {16'd0, pwm_cnt}, 32'd16);
        tick();
        #1;
        chk("alt_back_idle", {30'd0, grant}, 32'd0);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        #1;
        chk("clr_avoid", {16'd0, avoid_cnt}, 32'd0);
        chk("clr_pwm", {16'd0, pwm_cnt}, 32'd0);

        // ---- PWM alone for 20 words: no gap at the burst boundary
        bus.pwm_valid = 1'b1;
        #1;
        chk("pwm_idle_rdy", {31'd0, bus.pwm_rdy}, 32'd0);
        for (int k = 0; k < 20; k++) begin
            tick();
            bus.pwm_data = 16'hC000 | 16'(k);
            #1;
            chk($sformatf("pwm_grant_%0d", k), {30'd0, grant}, 32'd2);
            chk($sformatf("pwm_rdy_%0d", k), {31'd0, bus.pwm_rdy}, 32'd1);
        end
        tick();
        bus.pwm_valid = 1'b0;
        #1;
        chk("pwm_only_cnt", {16'd0, pwm_cnt}, 32'd20);
        chk("pwm_only_avoid", {16'd0, avoid_cnt}, 32'd0);
        tick();
        #1;
        chk("pwm_only_idle", {30'd0, grant}, 32'd0);

        // ---- Avoidance stalled by a full FIFO keeps its grant
        bus.avoid_valid = 1'b1;
        bus.avoid_data  = 16'h5A5A;
        bus.pwm_valid   = 1'b1;
        bus.out_rdy     = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            #1;
            chk($sformatf("stall_grant_%0d", k), {30'd0, grant}, 32'd1);
            chk($sformatf("stall_rdy_%0d", k), {30'd0, bus.avoid_rdy, bus.pwm_rdy}, 32'd0);
        end
        chk("stall_avoid_cnt", {16'd0, avoid_cnt}, 32'd0);
        chk("stall_pwm_cnt", {16'd0, pwm_cnt}, 32'd20);

        // ---- Reset on the 4th Avoidance word aborts the grant
        bus.out_rdy = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_pre_cnt", {16'd0, avoid_cnt}, 32'd3);
        tick();
        #1;
        chk("midrst_grant", {30'd0, grant}, 32'd0);
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_avoid_cnt", {16'd0, avoid_cnt}, 32'd0);
        chk("midrst_pwm_cnt", {16'd0, pwm_cnt}, 32'd0);
        rst = 1'b1;
        tick();
        #1;
        chk("midrst_first_grant", {30'd0, grant}, 32'd1);
        tick();
        bus.avoid_valid = 1'b0;
        bus.pwm_valid   = 1'b0;
        #1;
        chk("midrst_one_word", {16'd0, avoid_cnt}, 32'd1);
        tick();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        #1;
        chk("pre_sat_clear", {16'd0, pwm_cnt}, 32'd0);

        // ---- PWM counter saturation and clear-beats-transfer
        bus.pwm_valid = 1'b1;
        bus.pwm_data  = 16'h7E57;
        for (int k = 0; k < 65535; k++) tick();
        chk("sat_fffe", {16'd0, pwm_cnt}, 32'h0000FFFE);
        tick();
        chk("sat_ffff", {16'd0, pwm_cnt}, 32'h0000FFFF);
        tick();
        tick();
        chk("sat_hold", {16'd0, pwm_cnt}, 32'h0000FFFF);
        chk("sat_grant", {30'd0, grant}, 32'd2);
        clr_cnt = 1'b1;
        #1;
        chk("clr_xfer_rdy", {31'd0, bus.pwm_rdy}, 32'd1);
        tick();
        clr_cnt = 1'b0;
        #1;
        chk("clr_wins", {16'd0, pwm_cnt}, 32'd0);
        tick();
        chk("clr_resume", {16'd0, pwm_cnt}, 32'd1);

        // ---- Owner drops while the other waits: immediate handover
        bus.pwm_valid   = 1'b0;
        bus.avoid_valid = 1'b1;
        tick();
        #1;
        chk("handover_grant", {30'd0, grant}, 32'd1);
        chk("handover_busy", {31'd0, busy}, 32'd1);
        bus.avoid_valid = 1'b0;
        tick();
        tick();
        #1;
        chk("final_idle", {30'd0, grant}, 32'd0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/bc_arbiter.md
BC_ARBITER -- requirements
Module: bc_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, sets the breadcrumb word width.
REQ-002 Parameter MAX_BURST, default 8, range 1-255, sets the maximum words per grant when the other source is requesting.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset; sampled on rising clk.
REQ-005 avoid_data  input  DATA_W  breadcrumb word from the Avoidance source.
REQ-006 avoid_valid  input  1  Avoidance word available.
REQ-007 avoid_rdy  output  1  Avoidance word accepted this cycle when high with avoid_valid.
REQ-008 pwm_data  input  DATA_W  word from the PWM source.
REQ-009 pwm_valid  input  1  PWM word available.
REQ-010 pwm_rdy  output  1  PWM word accepted this cycle when high with pwm_valid.
REQ-011 out_data  output  DATA_W  word to the shared breadcrumb FIFO write port.
REQ-012 out_valid  output  1  drives the FIFO wr_en.
REQ-013 out_rdy  input  1  FIFO not full (~full).
REQ-014 grant  output  2  one-hot current owner: 2'b01 Avoidance, 2'b10 PWM, 2'b00 none.
REQ-015 busy  output  1  high when grant != 0.
REQ-016 clr_cnt  input  1  synchronous clear of both word counters.
REQ-017 avoid_cnt  output  16  words transferred from Avoidance since the last clear.
REQ-018 pwm_cnt  output  16  words transferred from PWM since the last clear.

Function
REQ-019 The block SHALL implement an FSM with states IDLE, GNT_A and GNT_P; grant SHALL be decoded from the state register only.
REQ-020 In IDLE: out_valid=0, avoid_rdy=0, pwm_rdy=0, out_data=0.
REQ-021 In GNT_A: out_data=avoid_data, out_valid=avoid_valid, avoid_rdy=out_rdy, pwm_rdy=0; GNT_P mirrors this for PWM. These paths SHALL be combinational, with zero added latency.
REQ-022 A transfer is defined as out_valid & out_rdy in a cycle; no other condition moves data.
REQ-023 IDLE exit: if exactly one source is valid, go to that grant next cycle. If both are valid, grant the source that did not hold last_owner. Otherwise remain in IDLE. First-word latency from valid to earliest transfer is 1 cycle.
REQ-024 burst_cnt (8 bit) SHALL clear on entry to any grant state and increment on each transfer.
REQ-025 In GNT_x, if the owner's valid is low, go to the other grant if the other source is valid, else go to IDLE. burst_cnt clears.
REQ-026 In GNT_x, on a transfer that makes burst_cnt reach MAX_BURST:
- if the other source is valid, go to the other grant;
- otherwise stay in GNT_x with burst_cnt cleared.
REQ-027 A stalled owner (valid high, out_rdy low) SHALL keep the grant indefinitely; burst_cnt does not advance.
REQ-028 last_owner SHALL update to the owning source on every exit from GNT_A or GNT_P.
REQ-029 avoid_cnt and pwm_cnt SHALL increment by 1 per transfer of their source and saturate at 16'hFFFF.
REQ-030 If clr_cnt and a transfer occur in the same cycle, clr_cnt SHALL win and the counter reads 0 next cycle.
REQ-031 out_valid SHALL never be high with grant=0, and avoid_rdy and pwm_rdy SHALL never be high together.

Reset
REQ-032 When rst=0 at a rising clk, the next state SHALL be: state=IDLE, last_owner=PWM (so Avoidance wins the first tie), burst_cnt=0, avoid_cnt=0, pwm_cnt=0.
REQ-033 A reset asserted mid-burst SHALL abort the grant in the same edge. No word is counted in that cycle, and outputs follow REQ-020 from the next cycle.

Verification
REQ-034 Reset, then hold both sources valid with out_rdy=1 and MAX_BURST=8 -> grant=01 for 8 transfers, then 10 for 8, alternating; avoid_cnt=pwm_cnt=16 after 32 transfers.
REQ-035 Only pwm_valid=1 for 20 words with out_rdy=1 -> grant stays 10 throughout, with no IDLE gap at the 8-word boundary; pwm_cnt=20, avoid_cnt=0.
REQ-036 GNT_A with avoid_valid=1 and out_rdy=0 for 50 cycles while pwm_valid=1 -> grant holds 01, no counter change, avoid_rdy=0, pwm_rdy=0.
REQ-037 Preload pwm_cnt to 16'hFFFE, then send 3 PWM words -> pwm_cnt=16'hFFFF. Assert clr_cnt in the cycle of a transfer -> pwm_cnt=0.
REQ-038 Assert rst=0 on the 4th word of an Avoidance burst -> next cycle grant=00, out_valid=0, avoid_cnt=0. After release with both sources valid -> first grant is 01.
REQ-039 Bench assertions, every cycle: REQ-031 holds; out_data equals the owner's data whenever out_valid=1.
